// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
package rom_port_arbiter_pkg;

  localparam int          MEM_DEPTH = 1024;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: on conflict the requester that did not win last time is granted.
module rom_port_arbiter_rr_arb2
  import rom_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_owner_i == OWNER_LS) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction-ROM read port between IF (single word) and LS (bursts).
// Define ROM_ARB_ADDR_CHK_EN to flag misaligned / out-of-range beats as errors with zeroed data.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [31:0]      if_rdata_o,
  output logic             if_err_o,
  input  logic             ls_req_i,
  input  logic [31:0]      ls_addr_i,
  input  logic [LEN_W-1:0] ls_len_i,
  output logic             ls_gnt_o,
  output logic             ls_rvalid_o,
  output logic [31:0]      ls_rdata_o,
  output logic             ls_last_o,
  output logic             ls_err_o,
  output logic [31:0]      rom_addr_o,
  input  logic [31:0]      rom_data_i
);

  state_e           state_q;
  owner_e           lastOwner_q;
  logic [LEN_W-1:0] beatCnt_q;
  logic [31:0]      burstAddr_q;
  logic [31:0]      romAddr_q;
  logic             ifRvalid_q, ifErr_q;
  logic [31:0]      ifRdata_q;
  logic             lsRvalid_q, lsLast_q, lsErr_q;
  logic [31:0]      lsRdata_q;

  logic [LEN_W-1:0] lenEff;
  logic [1:0]       arbReq, arbGnt;
  logic             issueIf, issueLs, issueLast;
  logic [31:0]      issueAddr;
  logic             beatErr;
  logic [31:0]      beatData;

  always_comb begin
    lenEff = ls_len_i;
    if (ls_len_i == '0) begin
      lenEff = LEN_W'(1);
    end else if (ls_len_i > LEN_W'(MAX_BURST)) begin
      lenEff = LEN_W'(MAX_BURST);
    end
  end

  // Arbitration only happens in IDLE; a running burst owns the port outright.
  assign arbReq = (state_q == ST_IDLE) ? {ls_req_i, if_req_i} : 2'b00;

  rom_port_arbiter_rr_arb2 u_rr_arb2 (
    .req_i        (arbReq),
    .last_owner_i (lastOwner_q),
    .gnt_o        (arbGnt)
  );

  always_comb begin
    issueIf   = arbGnt[0];
    issueLs   = 1'b0;
    issueLast = 1'b0;
    issueAddr = romAddr_q;
    if (state_q == ST_BURST) begin
      issueLs   = 1'b1;
      issueAddr = burstAddr_q;
      issueLast = (beatCnt_q == LEN_W'(1));
    end else if (arbGnt[0]) begin
      issueAddr = if_addr_i;
    end else if (arbGnt[1]) begin
      issueLs   = 1'b1;
      issueAddr = ls_addr_i;
      issueLast = (lenEff == LEN_W'(1));
    end
  end

`ifdef ROM_ARB_ADDR_CHK_EN
  assign beatErr = (issueAddr[1:0] != 2'b00) || (issueAddr[31:2] >= 30'(MEM_DEPTH));
`else
  assign beatErr = 1'b0;
`endif

  assign beatData = beatErr ? ZERO_WORD : rom_data_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      lastOwner_q <= OWNER_LS;
      beatCnt_q   <= '0;
      burstAddr_q <= '0;
      romAddr_q   <= '0;
      ifRvalid_q  <= 1'b0;
      ifErr_q     <= 1'b0;
      ifRdata_q   <= ZERO_WORD;
      lsRvalid_q  <= 1'b0;
      lsLast_q    <= 1'b0;
      lsErr_q     <= 1'b0;
      lsRdata_q   <= ZERO_WORD;
    end else begin
      romAddr_q  <= issueAddr;
      ifRvalid_q <= issueIf;
      lsRvalid_q <= issueLs;
      lsLast_q   <= issueLs & issueLast;
      if (issueIf) begin
        ifRdata_q <= beatData;
        ifErr_q   <= beatErr;
      end
      if (issueLs) begin
        lsRdata_q <= beatData;
        lsErr_q   <= beatErr;
      end
      if (arbGnt[0]) begin
        lastOwner_q <= OWNER_IF;
      end else if (arbGnt[1]) begin
        lastOwner_q <= OWNER_LS;
      end
      case (state_q)
        ST_IDLE: begin
          if (arbGnt[1] && (lenEff != LEN_W'(1))) begin
            state_q     <= ST_BURST;
            beatCnt_q   <= lenEff - LEN_W'(1);
            burstAddr_q <= ls_addr_i + 32'd4;
          end
        end
        ST_BURST: begin
          beatCnt_q   <= beatCnt_q - LEN_W'(1);
          burstAddr_q <= burstAddr_q + 32'd4;
          if (issueLast) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt_o    = arbGnt[0];
  assign ls_gnt_o    = arbGnt[1];
  assign rom_addr_o  = issueAddr;
  assign if_rvalid_o = ifRvalid_q;
  assign if_rdata_o  = ifRdata_q;
  assign if_err_o    = ifErr_q;
  assign ls_rvalid_o = lsRvalid_q;
  assign ls_rdata_o  = lsRdata_q;
  assign ls_last_o   = lsLast_q;
  assign ls_err_o    = lsErr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rom_port_arbiter;

  localparam int MAX_BURST       = 8;
  localparam int LEN_W           = 4;
  localparam int MEM_DEPTH_WORDS = 1024;

  typedef struct {
    logic [31:0] addr;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             ifReq = 1'b0, lsReq = 1'b0;
  logic [31:0]      ifAddr = '0, lsAddr = '0;
  logic [LEN_W-1:0] lsLen = '0;
  logic             if_gnt_o, if_rvalid_o, if_err_o;
  logic             ls_gnt_o, ls_rvalid_o, ls_last_o, ls_err_o;
  logic [31:0]      if_rdata_o, ls_rdata_o, rom_addr_o, romData;

  int nCompared = 0;
  int nMismatched = 0;

  beat_t       burstQ[$];
  logic        mLastLs = 1'b1;
  logic [31:0] mRomAddr = '0;
  logic        expIfValid = 0, expIfErr = 0, expLsValid = 0, expLsErr = 0, expLsLast = 0;
  logic [31:0] expIfData = '0, expLsData = '0;
  logic        gntIf = 0, gntLs = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  function automatic logic isErr(input logic [31:0] a);
`ifdef ROM_ARB_ADDR_CHK_EN
    return ((a % 4) != 0) || ((a / 4) >= 32'(MEM_DEPTH_WORDS));
`else
    return (a === 32'hx);
`endif
  endfunction

  assign romData = romWord(rom_addr_o);

  rom_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .if_req_i    (ifReq),
    .if_addr_i   (ifAddr),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .ls_req_i    (lsReq),
    .ls_addr_i   (lsAddr),
    .ls_len_i    (lsLen),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .ls_last_o   (ls_last_o),
    .ls_err_o    (ls_err_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (romData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: decide what the model issues, compare, then advance to just after the edge.
  task automatic runCycle();
    logic        eGntIf, eGntLs, isIf, isLs, isLast;
    logic [31:0] a;
    beat_t       b;
    int          n;
    @(negedge clk);
    eGntIf = 0; eGntLs = 0; isIf = 0; isLs = 0; isLast = 0;
    a = mRomAddr;
    if (burstQ.size() > 0) begin
      b = burstQ.pop_front();
      a = b.addr; isLs = 1; isLast = b.last;
    end else if (ifReq && (!lsReq || mLastLs)) begin
      eGntIf = 1; isIf = 1; a = ifAddr; mLastLs = 0;
    end else if (lsReq) begin
      n = (lsLen == 0) ? 1 : ((int'(lsLen) > MAX_BURST) ? MAX_BURST : int'(lsLen));
      eGntLs = 1; isLs = 1; a = lsAddr; isLast = (n == 1); mLastLs = 1;
      for (int k = 1; k < n; k++) burstQ.push_back('{addr: lsAddr + 32'(4 * k), last: (k == n - 1)});
    end
    mRomAddr = a;

    checkOutput("if_rvalid", 32'(if_rvalid_o), 32'(expIfValid));
    checkOutput("if_rdata", if_rdata_o, expIfData);
    checkOutput("if_err", 32'(if_err_o & if_rvalid_o), 32'(expIfErr & expIfValid));
    checkOutput("ls_rvalid", 32'(ls_rvalid_o), 32'(expLsValid));
    checkOutput("ls_rdata", ls_rdata_o, expLsData);
    checkOutput("ls_last", 32'(ls_last_o & ls_rvalid_o), 32'(expLsLast));
    checkOutput("ls_err", 32'(ls_err_o & ls_rvalid_o), 32'(expLsErr & expLsValid));
    checkOutput("if_gnt", 32'(if_gnt_o), 32'(eGntIf));
    checkOutput("ls_gnt", 32'(ls_gnt_o), 32'(eGntLs));
    checkOutput("rom_addr", rom_addr_o, a);

    expIfValid = isIf;
    if (isIf) begin
      expIfErr  = isErr(a);
      expIfData = expIfErr ? 32'h0 : romWord(a);
    end
    expLsValid = isLs;
    expLsLast  = isLs & isLast;
    if (isLs) begin
      expLsErr  = isErr(a);
      expLsData = expLsErr ? 32'h0 : romWord(a);
    end
    gntIf = eGntIf;
    gntLs = eGntLs;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic lr,
                               input logic [31:0] la, input logic [LEN_W-1:0] ll);
    ifReq = ir; ifAddr = ia; lsReq = lr; lsAddr = la; lsLen = ll;
    runCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, 32'h0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic resetDut(input int holdCycles);
    ifReq = 0; lsReq = 0;
    #2 arst_n = 1'b0;
    #1;
    checkOutput("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
    checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
    checkOutput("rst_if_err", 32'(if_err_o), 32'h0);
    checkOutput("rst_ls_rvalid", 32'(ls_rvalid_o), 32'h0);
    checkOutput("rst_ls_rdata", ls_rdata_o, 32'h0);
    checkOutput("rst_ls_last", 32'(ls_last_o), 32'h0);
    checkOutput("rst_ls_err", 32'(ls_err_o), 32'h0);
    checkOutput("rst_gnts", {30'h0, ls_gnt_o, if_gnt_o}, 32'h0);
    checkOutput("rst_rom_addr", rom_addr_o, 32'h0);
    burstQ.delete();
    mLastLs = 1; mRomAddr = '0;
    expIfValid = 0; expIfErr = 0; expIfData = '0;
    expLsValid = 0; expLsErr = 0; expLsLast = 0; expLsData = '0;
    gntIf = 0; gntLs = 0;
    repeat (holdCycles) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 1100)) * 4;
      6, 7:             return $urandom;
      8:                return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
      default:          return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    resetDut(2);

    // Back-to-back fetches
    applyStimulus(1, 32'h0, 0, 32'h0, '0);
    applyStimulus(1, 32'h4, 0, 32'h0, '0);
    applyStimulus(1, 32'h8, 0, 32'h0, '0);
    idleCycles(2);

    // Burst of 4 blocks a pending fetch until its last beat
    applyStimulus(1, 32'h20, 1, 32'h10, 4'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h20, 0, 32'h0, '0);
    idleCycles(2);

    // Both held from reset: IF, LS, IF, LS ...
    resetDut(1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 32'h40, 1, 32'h80, 4'd1);
    idleCycles(2);

    // Length 0 and over-length clamp
    applyStimulus(0, 32'h0, 1, 32'h100, 4'd0);
    idleCycles(2);
    applyStimulus(0, 32'h0, 1, 32'h200, 4'd11);
    idleCycles(MAX_BURST + 2);

    // Address wrap across 2^32
    applyStimulus(0, 32'h0, 1, 32'hFFFF_FFFC, 4'd2);
    idleCycles(3);

    // Reset during beat 2 of a 6-beat burst
    applyStimulus(0, 32'h0, 1, 32'h300, 4'd6);
    idleCycles(1);
    resetDut(2);
    idleCycles(6);

    // Misaligned fetch
    applyStimulus(1, 32'h2, 0, 32'h0, '0);
    idleCycles(2);

    // Random traffic with held requests until granted
    ifReq = 0; lsReq = 0; gntIf = 0; gntLs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) resetDut(1);
      if (!ifReq || gntIf) begin
        ifReq  = ($urandom_range(0, 2) != 0);
        ifAddr = randAddr();
      end
      if (!lsReq || gntLs) begin
        lsReq  = ($urandom_range(0, 3) == 0);
        lsAddr = randAddr();
        lsLen  = LEN_W'($urandom_range(0, 15));
      end
      runCycle();
    end
    idleCycles(MAX_BURST + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
